// File: rtl/sound1942_pkg.sv
// Shared types and constants for the 1942 sound-command path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sound1942_pkg;

  // Latch presenter state: IDLE has no unretired code, PRESENT holds one.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Value the latch shows when cleared on retire.
  localparam logic [7:0]  IDLE_CODE  = 8'h00;
  // Sound-CPU address of the command latch; decoded outside this block.
  localparam logic [15:0] LATCH_ADDR = 16'h6000;

endpackage

// File: rtl/sound_cmd_fifo.sv
// Synchronous FIFO holding queued sound codes behind the latch.
// Latency: push visible at dout/level one cycle later; dout is the head, read combinationally.
// Backpressure: full flag; caller must not push when full nor pop when empty.
// Ports: clk/reset (sync, active-high), push/din, pop/dout, full, empty, level.
module sound_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_q, rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign level = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/sound_cmd_writer.sv
// Queues main-CPU sound codes and presents them one at a time on the sound-CPU latch.
// Latency: write in IDLE shows on latch_dout next cycle; next code shows the cycle after the final read ends.
// Backpressure: cmd_ready low when FIFO full; writes while full are dropped and set sticky overflow.
// Ports: clk/reset (sync, active-high); cmd_we/cmd_data/cmd_ready write side;
//        latch_cs/latch_rd/latch_dout/latch_valid sound-CPU side; fifo_level, overflow status.
module sound_cmd_writer
  import sound1942_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HOLD_READS = 1,
  parameter int IDLE_CLEAR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_we,
  input  logic [7:0]               cmd_data,
  output logic                     cmd_ready,
  input  logic                     latch_cs,
  input  logic                     latch_rd,
  output logic [7:0]               latch_dout,
  output logic                     latch_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam logic [3:0] HOLD = 4'(HOLD_READS);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] latch_q, latch_d;
  logic       s_q, overflow_q;

  logic       s, rd_done, bypass;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  // A read completes when the decoded strobe falls, so a long read counts once
  // and the latch can only move while the sound CPU is not sampling it.
  assign s       = latch_cs & latch_rd;
  assign rd_done = s_q & ~s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Leftover queue entries go first; a write then queues behind them.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          latch_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = ST_PRESENT;
        end else if (cmd_we) begin
          bypass  = 1'b1;
          latch_d = cmd_data;
          cnt_d   = '0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (rd_done) begin
          if (cnt_q + 4'd1 == HOLD) begin
            cnt_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              latch_d  = fifo_dout;
            end else begin
              state_d = ST_IDLE;
              if (IDLE_CLEAR != 0) latch_d = IDLE_CODE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full is judged on registered state: a same-cycle pop does not make room.
  assign fifo_push = cmd_we & ~bypass & ~fifo_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      latch_q    <= IDLE_CODE;
      s_q        <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      s_q     <= s;
      if (cmd_we && !bypass && fifo_full) overflow_q <= 1'b1;
    end
  end

  sound_cmd_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (cmd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_ready   = ~fifo_full;
  assign latch_dout  = latch_q;
  assign latch_valid = (state_q == ST_PRESENT);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sound_cmd_writer.sv
// Directed bench: instance a uses default parameters, instance b uses HOLD_READS=3, IDLE_CLEAR=1.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants.
module tb_sound_cmd_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       a_we, a_cs, a_rd, b_we, b_cs, b_rd;
  logic [7:0] a_data, b_data;
  logic       a_ready, a_valid, a_ovf, b_ready, b_valid, b_ovf;
  logic [7:0] a_dout, b_dout;
  logic [2:0] a_level, b_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sound_cmd_writer #(.DEPTH(4), .HOLD_READS(1), .IDLE_CLEAR(0)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_we(a_we), .cmd_data(a_data), .cmd_ready(a_ready),
    .latch_cs(a_cs), .latch_rd(a_rd), .latch_dout(a_dout), .latch_valid(a_valid),
    .fifo_level(a_level), .overflow(a_ovf)
  );

  sound_cmd_writer #(.DEPTH(4), .HOLD_READS(3), .IDLE_CLEAR(1)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_we(b_we), .cmd_data(b_data), .cmd_ready(b_ready),
    .latch_cs(b_cs), .latch_rd(b_rd), .latch_dout(b_dout), .latch_valid(b_valid),
    .fifo_level(b_level), .overflow(b_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write per cycle into instance a.
  task automatic wr_a(input logic [7:0] d);
    a_we = 1'b1; a_data = d;
    tick();
    a_we = 1'b0;
  endtask

  // Read pulse with strobe high n cycles; latch must hold exp_hold throughout.
  // Optionally a write lands on the same edge the read completes.
  task automatic rd(input bit sel_b, input int n, input logic [7:0] exp_hold,
                    input logic we, input logic [7:0] d);
    if (sel_b) begin b_cs = 1'b1; b_rd = 1'b1; end
    else       begin a_cs = 1'b1; a_rd = 1'b1; end
    for (int i = 0; i < n; i++) begin
      tick();
      chk("stable_while_rd", sel_b ? b_dout : a_dout, exp_hold);
    end
    if (sel_b) begin b_cs = 1'b0; b_rd = 1'b0; end
    else       begin a_cs = 1'b0; a_rd = 1'b0; a_we = we; a_data = d; end
    tick();
    a_we = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_dout"},  a_dout,  8'h00);
    chk({tag, "_valid"}, a_valid, 1'b0);
    chk({tag, "_ready"}, a_ready, 1'b1);
    chk({tag, "_level"}, a_level, 3'd0);
    chk({tag, "_ovf"},   a_ovf,   1'b0);
  endtask

  initial begin
    reset = 1'b1;
    a_we = 0; a_cs = 0; a_rd = 0; a_data = 8'h00;
    b_we = 0; b_cs = 0; b_rd = 0; b_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk_reset_a("rst");
    chk("rst_b_valid", b_valid, 1'b0);

    // Single code bypasses the FIFO, retires after one read, latch held.
    wr_a(8'h12);
    chk("byp_dout", a_dout, 8'h12);
    chk("byp_valid", a_valid, 1'b1);
    chk("byp_level", a_level, 3'd0);
    rd(0, 3, 8'h12, 1'b0, 8'h00);
    chk("ret_valid", a_valid, 1'b0);
    chk("ret_dout_held", a_dout, 8'h12);

    // Three back-to-back codes presented in order.
    wr_a(8'h12); wr_a(8'h05); wr_a(8'h0A);
    chk("seq_dout0", a_dout, 8'h12);
    chk("seq_level0", a_level, 3'd2);
    rd(0, 2, 8'h12, 1'b0, 8'h00);
    chk("seq_dout1", a_dout, 8'h05);
    chk("seq_level1", a_level, 3'd1);
    chk("seq_valid1", a_valid, 1'b1);
    rd(0, 1, 8'h05, 1'b0, 8'h00);
    chk("seq_dout2", a_dout, 8'h0A);
    chk("seq_level2", a_level, 3'd0);
    rd(0, 4, 8'h0A, 1'b0, 8'h00);
    chk("seq_idle_valid", a_valid, 1'b0);
    chk("seq_idle_dout", a_dout, 8'h0A);

    // Overflow: 1 in latch, 2..5 queued, 6 dropped.
    for (int i = 1; i <= 6; i++) wr_a(8'(i));
    chk("ovf_dout", a_dout, 8'h01);
    chk("ovf_level", a_level, 3'd4);
    chk("ovf_ready", a_ready, 1'b0);
    chk("ovf_flag", a_ovf, 1'b1);
    rd(0, 1, 8'h01, 1'b0, 8'h00);
    chk("ovf_dout2", a_dout, 8'h02);
    chk("ovf_ready2", a_ready, 1'b1);
    chk("ovf_level2", a_level, 3'd3);
    rd(0, 1, 8'h02, 1'b0, 8'h00);
    chk("ovf_dout3", a_dout, 8'h03);
    rd(0, 1, 8'h03, 1'b0, 8'h00);
    chk("ovf_dout4", a_dout, 8'h04);
    rd(0, 1, 8'h04, 1'b0, 8'h00);
    chk("ovf_dout5", a_dout, 8'h05);
    rd(0, 1, 8'h05, 1'b0, 8'h00);
    chk("ovf_drop_valid", a_valid, 1'b0);
    chk("ovf_drop_dout", a_dout, 8'h05);
    chk("ovf_sticky", a_ovf, 1'b1);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("ovf_cleared", a_ovf, 1'b0);

    // Push on the retire edge while two are queued.
    wr_a(8'hA1); wr_a(8'hA2); wr_a(8'hA3);
    chk("pp_level0", a_level, 3'd2);
    rd(0, 2, 8'hA1, 1'b1, 8'hA4);
    chk("pp_dout", a_dout, 8'hA2);
    chk("pp_level", a_level, 3'd2);
    rd(0, 1, 8'hA2, 1'b0, 8'h00);
    chk("pp_dout3", a_dout, 8'hA3);
    chk("pp_level3", a_level, 3'd1);
    rd(0, 1, 8'hA3, 1'b0, 8'h00);
    chk("pp_dout4", a_dout, 8'hA4);
    chk("pp_level4", a_level, 3'd0);
    rd(0, 1, 8'hA4, 1'b0, 8'h00);
    chk("pp_idle", a_valid, 1'b0);

    // Reset while presenting with three queued, then fresh bypass.
    wr_a(8'hB1); wr_a(8'hB2); wr_a(8'hB3); wr_a(8'hB4);
    chk("mr_level", a_level, 3'd3);
    chk("mr_valid", a_valid, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_a("mr");
    wr_a(8'h33);
    chk("mr_byp_dout", a_dout, 8'h33);
    chk("mr_byp_valid", a_valid, 1'b1);
    chk("mr_byp_level", a_level, 3'd0);

    // Instance b: three reads needed, latch clears on retire.
    b_we = 1'b1; b_data = 8'h20;
    tick();
    b_we = 1'b0;
    chk("h3_dout", b_dout, 8'h20);
    chk("h3_valid", b_valid, 1'b1);
    rd(1, 1, 8'h20, 1'b0, 8'h00);
    chk("h3_valid1", b_valid, 1'b1);
    rd(1, 2, 8'h20, 1'b0, 8'h00);
    chk("h3_valid2", b_valid, 1'b1);
    chk("h3_dout2", b_dout, 8'h20);
    rd(1, 1, 8'h20, 1'b0, 8'h00);
    chk("h3_retired", b_valid, 1'b0);
    chk("h3_cleared", b_dout, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
